waterlight_driver: RTL and testbench

Pattern engine that sits directly downstream of the AHB-Lite WaterLight register slave. It consumes the registered `mode` (8-bit) and `speed` (32-bit) values and drives the board LED bank. It runs an internal prescaler and a pattern state machine that advances the LED pattern once every `speed` HCLK cycles. All outputs are registered, and there is no bus interface.

---
 rtl/waterlight_pkg.sv | 55 +++++
 rtl/waterlight_prescaler.sv | 39 +++
 rtl/waterlight_driver.sv | 98 +++++++++
 tb/tb_waterlight_driver.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/waterlight_pkg.sv
// Shared definitions for the WaterLight pattern engine: mode codes, pattern
// states and the per-mode initial pattern shapes.
package waterlight_pkg;

    localparam int WL_CNT_W = 32;

    localparam logic [7:0] WL_MODE_ROTL   = 8'h01;
    localparam logic [7:0] WL_MODE_ROTR   = 8'h02;
    localparam logic [7:0] WL_MODE_FLASH  = 8'h03;
    localparam logic [7:0] WL_MODE_BOUNCE = 8'h04;

    typedef enum logic [2:0] {
        WL_ST_IDLE,
        WL_ST_ROTL,
        WL_ST_ROTR,
        WL_ST_FLASH,
        WL_ST_BOUNCE_L,
        WL_ST_BOUNCE_R
    } wl_state_e;

    // Initial patterns are described by shape so they scale with the LED width.
    typedef enum logic [1:0] {
        WL_FILL_NONE,
        WL_FILL_LSB,
        WL_FILL_MSB,
        WL_FILL_ALL
    } wl_fill_e;

    localparam wl_fill_e WL_INIT_IDLE   = WL_FILL_NONE;
    localparam wl_fill_e WL_INIT_ROTL   = WL_FILL_LSB;
    localparam wl_fill_e WL_INIT_ROTR   = WL_FILL_MSB;
    localparam wl_fill_e WL_INIT_FLASH  = WL_FILL_ALL;
    localparam wl_fill_e WL_INIT_BOUNCE = WL_FILL_LSB;

    function automatic wl_state_e wl_decode(input logic [7:0] m, input logic dir_right);
        case (m)
            WL_MODE_ROTL:   return WL_ST_ROTL;
            WL_MODE_ROTR:   return WL_ST_ROTR;
            WL_MODE_FLASH:  return WL_ST_FLASH;
            WL_MODE_BOUNCE: return dir_right ? WL_ST_BOUNCE_R : WL_ST_BOUNCE_L;
            default:        return WL_ST_IDLE;
        endcase
    endfunction

    function automatic wl_fill_e wl_init_fill(input logic [7:0] m);
        case (m)
            WL_MODE_ROTL:   return WL_INIT_ROTL;
            WL_MODE_ROTR:   return WL_INIT_ROTR;
            WL_MODE_FLASH:  return WL_INIT_FLASH;
            WL_MODE_BOUNCE: return WL_INIT_BOUNCE;
            default:        return WL_INIT_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/waterlight_prescaler.sv
// Step-period prescaler: counts HCLK cycles and pulses tick once every
// speed cycles; holds at zero when disabled, cleared, or speed is 0.
module waterlight_prescaler
    import waterlight_pkg::*;
(
    input  logic                HCLK,
    input  logic                HRESETn,
    input  logic [WL_CNT_W-1:0] speed,
    input  logic                enable,
    input  logic                clear,
    output logic                tick,
    output logic [WL_CNT_W-1:0] cnt
);

    logic [WL_CNT_W-1:0] cnt_q, cnt_d;
    logic                run;

    assign run = enable && (speed != '0) && !clear;
    // >= rather than == so a speed drop below the current count fires at once.
    assign tick = run && (cnt_q >= (speed - WL_CNT_W'(1)));

    always_comb begin
        cnt_d = cnt_q + WL_CNT_W'(1);
        if (!run || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/waterlight_driver.sv
// WaterLight pattern engine: turns the registered mode/speed settings into a
// stepped LED pattern with a one-cycle step pulse.
module waterlight_driver
    import waterlight_pkg::*;
#(
    parameter int LED_W = 8
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic [7:0]       mode,
    input  logic [31:0]      speed,
    output logic [LED_W-1:0] led,
    output logic             step
);

    logic [7:0]       mode_q;
    logic             chg_q;
    logic             dir_q, dir_d;
    logic [LED_W-1:0] led_q, led_d;
    logic             step_q;
    logic             chg, tick, run_en;
    logic [31:0]      presc_cnt;
    wl_state_e        state;

    function automatic logic [LED_W-1:0] fill_pattern(input wl_fill_e f);
        logic [LED_W-1:0] p;
        p = '0;
        case (f)
            WL_FILL_LSB: p[0] = 1'b1;
            WL_FILL_MSB: p[LED_W-1] = 1'b1;
            WL_FILL_ALL: p = '1;
            default:     p = '0;
        endcase
        return p;
    endfunction

    // The change is seen one edge early (chg) to suppress a coincident step,
    // and the new pattern is loaded on the following edge (chg_q).
    assign chg    = (mode != mode_q);
    assign state  = wl_decode(mode_q, dir_q);
    assign run_en = (state != WL_ST_IDLE);

    waterlight_prescaler u_presc (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .speed   (speed),
        .enable  (run_en),
        .clear   (chg | chg_q),
        .tick    (tick),
        .cnt     (presc_cnt)
    );

    always_comb begin
        led_d = led_q;
        dir_d = dir_q;
        if (chg || chg_q) begin
            dir_d = 1'b0;
        end
        if (chg_q) begin
            led_d = fill_pattern(wl_init_fill(mode_q));
        end else if (tick) begin
            case (state)
                WL_ST_ROTL:  led_d = {led_q[LED_W-2:0], led_q[LED_W-1]};
                WL_ST_ROTR:  led_d = {led_q[0], led_q[LED_W-1:1]};
                WL_ST_FLASH: led_d = ~led_q;
                WL_ST_BOUNCE_L: begin
                    led_d = led_q << 1;
                    if (led_d[LED_W-1]) dir_d = 1'b1;
                end
                WL_ST_BOUNCE_R: begin
                    led_d = led_q >> 1;
                    if (led_d[0]) dir_d = 1'b0;
                end
                default:     led_d = '0;
            endcase
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            mode_q <= 8'h00;
            chg_q  <= 1'b0;
            dir_q  <= 1'b0;
            led_q  <= '0;
            step_q <= 1'b0;
        end else begin
            mode_q <= mode;
            chg_q  <= chg;
            dir_q  <= dir_d;
            led_q  <= led_d;
            step_q <= tick;
        end
    end

    assign led  = led_q;
    assign step = step_q;

endmodule

// File: tb/tb_waterlight_driver.sv
// Scoreboard bench for waterlight_driver: stimulus queues the expected
// (cycle, led) of every step pulse, a monitor checks them as they appear.
module tb_waterlight_driver;

    logic        HCLK;
    logic        HRESETn;
    logic [7:0]  mode;
    logic [31:0] speed;
    logic [7:0]  led;
    logic        step;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int exp_cyc[$];
    logic [7:0] exp_led[$];

    logic [7:0] rotl_seq   [8]  = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
    logic [7:0] bounce_seq [16] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                                    8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02, 8'h04};

    waterlight_driver #(.LED_W(8)) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .mode    (mode),
        .speed   (speed),
        .led     (led),
        .step    (step)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    always @(posedge HCLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int c, input logic [7:0] v);
        exp_cyc.push_back(c);
        exp_led.push_back(v);
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge HCLK);
    endtask

    // Monitor: every step pulse must match the head of the scoreboard.
    always @(negedge HCLK) begin
        if (HRESETn && step) begin
            if (exp_cyc.size() == 0) begin
                chk("unexpected_step_led", {24'h0, led}, 32'hFFFF_FFFF);
            end else begin
                int         c;
                logic [7:0] v;
                c = exp_cyc.pop_front();
                v = exp_led.pop_front();
                chk("step_cycle", cyc, c);
                chk("step_led", {24'h0, led}, {24'h0, v});
            end
        end
    end

    initial begin
        int b, s, x, y;
        HRESETn = 1'b0;
        mode    = 8'h01;
        speed   = 32'd4;
        repeat (3) @(negedge HCLK);
        chk("rst_led", {24'h0, led}, 32'h0);
        chk("rst_step", {31'h0, step}, 32'h0);
        chk("rst_cnt", dut.u_presc.cnt, 32'h0);

        HRESETn = 1'b1;
        b = cyc;
        wait_to(b + 1);
        chk("release_edge1_led", {24'h0, led}, 32'h0);
        wait_to(b + 2);
        chk("release_edge2_led", {24'h0, led}, 32'h01);
        chk("release_edge2_step", {31'h0, step}, 32'h0);

        // ROTL at speed 4, full lap including the 0x80 -> 0x01 wrap
        b = cyc;
        for (int k = 0; k < 8; k++) push(b + 4 * (k + 1), rotl_seq[k]);
        wait_to(b + 32);
        chk("rotl_wrap_led", {24'h0, led}, 32'h01);

        // Mode change on the terminal-count cycle
        wait_to(b + 35);
        chk("tc_cnt_before", dut.u_presc.cnt, 32'd3);
        mode = 8'h03;
        wait_to(b + 36);
        chk("tc_step_suppressed", {31'h0, step}, 32'h0);
        chk("tc_cnt_cleared", dut.u_presc.cnt, 32'h0);
        push(b + 41, 8'h00);
        push(b + 45, 8'hFF);
        wait_to(b + 37);
        chk("flash_init_led", {24'h0, led}, 32'hFF);
        chk("flash_init_step", {31'h0, step}, 32'h0);
        chk("flash_init_cnt", dut.u_presc.cnt, 32'h0);

        // ROTR to 0x20, then freeze with speed 0, then resume at speed 2
        wait_to(b + 46);
        mode  = 8'h02;
        speed = 32'd1;
        push(b + 49, 8'h40);
        push(b + 50, 8'h20);
        wait_to(b + 48);
        chk("rotr_init_led", {24'h0, led}, 32'h80);
        wait_to(b + 50);
        speed = 32'd0;
        wait_to(b + 56);
        chk("frozen_led", {24'h0, led}, 32'h20);
        chk("frozen_cnt", dut.u_presc.cnt, 32'h0);
        speed = 32'd2;
        s = cyc;
        push(s + 2, 8'h10);
        push(s + 4, 8'h08);

        // Speed decrease below the running count
        wait_to(s + 4);
        speed = 32'd1000;
        wait_to(s + 104);
        chk("slow_cnt", dut.u_presc.cnt, 32'd100);
        speed = 32'd10;
        push(s + 105, 8'h04);
        push(s + 115, 8'h02);
        push(s + 125, 8'h01);
        push(s + 135, 8'h80);

        // BOUNCE at speed 1: each end value shown for one cycle
        wait_to(s + 135);
        mode  = 8'h04;
        speed = 32'd1;
        x = cyc;
        for (int k = 0; k < 16; k++) push(x + 3 + k, bounce_seq[k]);
        wait_to(x + 2);
        chk("bounce_init_led", {24'h0, led}, 32'h01);

        // Unknown mode code behaves as IDLE
        wait_to(x + 18);
        mode = 8'h07;
        wait_to(x + 20);
        chk("idle_led", {24'h0, led}, 32'h0);
        wait_to(x + 30);
        chk("idle_led_hold", {24'h0, led}, 32'h0);
        chk("idle_step", {31'h0, step}, 32'h0);
        chk("idle_cnt", dut.u_presc.cnt, 32'h0);

        // Asynchronous reset in the middle of a running pattern
        mode  = 8'h01;
        speed = 32'd1;
        y = cyc;
        push(y + 3, 8'h02);
        push(y + 4, 8'h04);
        wait_to(y + 4);
        #2 HRESETn = 1'b0;
        #1;
        chk("async_rst_led", {24'h0, led}, 32'h0);
        chk("async_rst_step", {31'h0, step}, 32'h0);
        chk("async_rst_cnt", dut.u_presc.cnt, 32'h0);
        chk("async_rst_mode_q", {24'h0, dut.mode_q}, 32'h0);

        chk("scoreboard_drained", exp_cyc.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
